// File: rtl/serial_comparator.sv
//==============================================================================
// Module      : serial_comparator
// Description : Multi-cycle magnitude comparator for wide unsigned operands.
//               Captures A and B on an accepted start, walks them one nibble
//               per cycle from the MSB down, and carries a less/greater/equal
//               cascade state into each next nibble. Presents registered
//               l/g/m flags, the number of nibbles examined, and a done pulse.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_comparator #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  output logic                        busy,
  output logic                        done,
  output logic                        l,
  output logic                        g,
  output logic                        m,
  output logic [$clog2(WIDTH/4):0]    nib_used
);

  // Nibble count, index width (at least 1 bit) and counter width.
  localparam int c_NIBS = WIDTH / 4;
  localparam int c_IW   = (c_NIBS > 1) ? $clog2(c_NIBS) : 1;
  localparam int c_CW   = $clog2(c_NIBS) + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CMP  = 1'b1
  } state_t;

  // Cascade state: decided by the most significant unequal nibble so far.
  typedef enum logic [1:0] {
    C_EQ = 2'd0,
    C_LT = 2'd1,
    C_GT = 2'd2
  } casc_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [c_IW-1:0]   r_idx;
  casc_t             r_casc;
  logic [c_CW-1:0]   r_cnt;
  logic              r_done;
  logic              r_l;
  logic              r_g;
  logic              r_m;
  logic [c_CW-1:0]   r_nib_used;

  logic [3:0]        w_nib_a;
  logic [3:0]        w_nib_b;
  casc_t             w_nib_res;
  casc_t             w_casc_next;
  logic              w_accept;
  logic              w_finish;

  // Select the nibble currently addressed by r_idx from both captured operands.
  always_comb begin
    w_nib_a = 4'h0;
    w_nib_b = 4'h0;
    for (int i = 0; i < c_NIBS; i++) begin
      if (r_idx == c_IW'(i)) begin
        w_nib_a = r_a[i*4 +: 4];
        w_nib_b = r_b[i*4 +: 4];
      end
    end
  end

  // 4-bit compare of the current nibble, then fold into the cascade; a
  // decided cascade is never overridden by a lower nibble.
  always_comb begin
    w_nib_res = C_EQ;
    if (w_nib_a < w_nib_b) begin
      w_nib_res = C_LT;
    end else if (w_nib_a > w_nib_b) begin
      w_nib_res = C_GT;
    end
    w_casc_next = (r_casc == C_EQ) ? w_nib_res : r_casc;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: accept in IDLE, finish on last nibble or early exit.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_CMP;
        end
      end
      S_CMP: begin
        if ((r_idx == '0) || (EARLY_EXIT && (w_nib_res != C_EQ))) begin
          w_finish     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, nibble walk, cascade, and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_idx      <= '0;
      r_casc     <= C_EQ;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_l        <= 1'b0;
      r_g        <= 1'b0;
      r_m        <= 1'b0;
      r_nib_used <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_idx  <= c_IW'(c_NIBS - 1);
        r_casc <= C_EQ;
        r_cnt  <= '0;
      end
      if (r_state == S_CMP) begin
        r_casc <= w_casc_next;
        r_cnt  <= r_cnt + 1'b1;
        if (w_finish) begin
          r_l        <= (w_casc_next == C_LT);
          r_g        <= (w_casc_next == C_GT);
          r_m        <= (w_casc_next == C_EQ);
          r_nib_used <= r_cnt + 1'b1;
          r_done     <= 1'b1;
        end else begin
          r_idx <= r_idx - 1'b1;
        end
      end
    end
  end

  assign busy     = (r_state == S_CMP);
  assign done     = r_done;
  assign l        = r_l;
  assign g        = r_g;
  assign m        = r_m;
  assign nib_used = r_nib_used;

endmodule

`default_nettype wire

// File: tb/tb_serial_comparator.sv
//==============================================================================
// Module      : tb_serial_comparator
// Description : Scoreboard bench for serial_comparator. Three instances:
//               16-bit early-exit, 16-bit full-walk, and 4-bit early-exit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_comparator;

  typedef struct {
    logic [2:0] lgm;
    int         nused;
    int         lat;
    int         acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   compared;
  int   mismatched;

  // 16-bit, early exit
  logic        start16;
  logic [15:0] a16, b16;
  logic        busy16, done16, l16, g16, m16;
  logic [2:0]  nu16;
  // 16-bit, full walk
  logic        startne;
  logic [15:0] ane, bne;
  logic        busyne, donene, lne, gne, mne;
  logic [2:0]  nune;
  // 4-bit, early exit
  logic        start4;
  logic [3:0]  a4, b4;
  logic        busy4, done4, l4, g4, m4;
  logic [0:0]  nu4;

  exp_t q16[$];
  exp_t qne[$];
  exp_t q4[$];

  serial_comparator #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .l(l16), .g(g16), .m(m16), .nib_used(nu16));

  serial_comparator #(.WIDTH(16), .EARLY_EXIT(1'b0)) dutne (
    .clk(clk), .rst(rst), .start(startne), .a(ane), .b(bne),
    .busy(busyne), .done(donene), .l(lne), .g(gne), .m(mne), .nib_used(nune));

  serial_comparator #(.WIDTH(4), .EARLY_EXIT(1'b1)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .l(l4), .g(g4), .m(m4), .nib_used(nu4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer compare for the flags, MSB-first nibble scan for count.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input int w, input bit ee);
    exp_t e;
    int   n;
    bit   found;
    n       = w / 4;
    e.lgm   = (a < b) ? 3'b100 : ((a > b) ? 3'b010 : 3'b001);
    e.nused = n;
    e.acc   = 0;
    found   = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      if (ee && !found && (((a >> (4 * i)) & 16'hF) != ((b >> (4 * i)) & 16'hF))) begin
        e.nused = n - i;
        found   = 1'b1;
      end
    end
    e.lat = e.nused;
    return e;
  endfunction

  function automatic int qsize(input int which);
    case (which)
      0:       return q16.size();
      1:       return qne.size();
      default: return q4.size();
    endcase
  endfunction

  // Drive a start pulse; returns just after the edge that samples it.
  task automatic launch(input int which, input logic [15:0] av, input logic [15:0] bv,
                        input bit push);
    exp_t e;
    int   acc;
    case (which)
      0:       begin start16 = 1'b1; a16 = av; b16 = bv; end
      1:       begin startne = 1'b1; ane = av; bne = bv; end
      default: begin start4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; end
    endcase
    @(posedge clk);
    #1;
    acc = cyc;
    start16 = 1'b0;
    startne = 1'b0;
    start4  = 1'b0;
    if (push) begin
      case (which)
        0:       begin e = model(av, bv, 16, 1'b1); e.acc = acc; q16.push_back(e); end
        1:       begin e = model(av, bv, 16, 1'b0); e.acc = acc; qne.push_back(e); end
        default: begin e = model(av, bv, 4, 1'b1);  e.acc = acc; q4.push_back(e);  end
      endcase
    end
  endtask

  task automatic wait_drain(input int which, input int max_cycles);
    int n;
    n = 0;
    while (qsize(which) != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (qsize(which) != 0) check("drain_timeout", qsize(which), 0);
  endtask

  // Monitors: pop and compare each result when the DUT signals done.
  always @(negedge clk) begin : mon16
    exp_t e;
    if (!rst && done16) begin
      if (q16.size() == 0) begin
        check("d16_spurious_done", 1, 0);
      end else begin
        e = q16.pop_front();
        check("d16_lgm", {l16, g16, m16}, e.lgm);
        check("d16_nib_used", nu16, e.nused);
        check("d16_latency", cyc - e.acc, e.lat);
        check("d16_busy_at_done", busy16, 0);
      end
    end
  end

  always @(negedge clk) begin : monne
    exp_t e;
    if (!rst && donene) begin
      if (qne.size() == 0) begin
        check("dne_spurious_done", 1, 0);
      end else begin
        e = qne.pop_front();
        check("dne_lgm", {lne, gne, mne}, e.lgm);
        check("dne_nib_used", nune, e.nused);
        check("dne_latency", cyc - e.acc, e.lat);
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        check("d4_spurious_done", 1, 0);
      end else begin
        e = q4.pop_front();
        check("d4_lgm", {l4, g4, m4}, e.lgm);
        check("d4_nib_used", nu4, e.nused);
        check("d4_latency", cyc - e.acc, e.lat);
      end
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0;
    startne = 1'b0; ane = '0; bne = '0;
    start4  = 1'b0; a4  = '0; b4  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle outputs after reset, held for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_idle16", {busy16, done16, l16, g16, m16, nu16}, 0);
    end
    check("rst_idle_ne", {busyne, donene, lne, gne, mne, nune}, 0);
    check("rst_idle4", {busy4, done4, l4, g4, m4, nu4}, 0);

    // Equal operands walk every nibble; MSB-decided and LSB-decided cases.
    launch(0, 16'h1234, 16'h1234, 1'b1); wait_drain(0, 20);
    launch(0, 16'h8000, 16'h7FFF, 1'b1); wait_drain(0, 20);
    launch(0, 16'h1233, 16'h1234, 1'b1); wait_drain(0, 20);

    // Full walk: the lower nibbles must not override the MSB decision.
    launch(1, 16'h8000, 16'h7FFF, 1'b1); wait_drain(1, 20);
    launch(1, 16'h0001, 16'h0000, 1'b1); wait_drain(1, 20);

    // Start while busy is ignored; start in the done cycle is accepted.
    launch(0, 16'h00F0, 16'h0F00, 1'b1);   // accept edge E0, done after E2
    start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0000;
    @(posedge clk); #1;                     // E1: in CMP, must be ignored
    start16 = 1'b0;
    @(posedge clk); #1;                     // E2 finished: done cycle
    check("b2b_done_cycle", {done16, busy16}, 2'b10);
    launch(0, 16'h0000, 16'h0000, 1'b1);   // accepted at E3
    wait_drain(0, 20);

    // Reset during the second CMP cycle clears outputs at once; no done.
    launch(0, 16'h5555, 16'h5555, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_clear", {busy16, done16, l16, g16, m16, nu16}, 0);
    q16.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_quiet", {busy16, done16, l16, g16, m16, nu16}, 0);

    // Exhaustive 4-bit sweep.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        launch(2, 16'(ia), 16'(ib), 1'b1);
        wait_drain(2, 10);
      end
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
